// File: rtl/control_fsm_pkg.sv
// Shared types for the multicycle control FSM and its interrupt front end.
package control_fsm_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'b000,
    ST_FETCH     = 3'b001,
    ST_EXEC      = 3'b010,
    ST_MEM_WAIT  = 3'b011,
    ST_WRITEBACK = 3'b100,
    ST_TRAP      = 3'b101
  } fsm_state_t;

  // Cause codes 0..NUM_IRQ-1 are interrupt lines; NUM_IRQ itself is the bus error.
  function automatic int cause_width(input int num_irq);
    return $clog2(num_irq + 1);
  endfunction

endpackage

// File: rtl/control_fsm_mc_irq_pending.sv
// Edge-latched interrupt pending bits with per-line mask and fixed priority
// (index 0 highest).
module irq_pending import control_fsm_pkg::*; #(
  parameter int NUM_IRQ = 4,
  parameter int CW      = cause_width(NUM_IRQ)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic [NUM_IRQ-1:0] IRQ_EN,
  input  logic [CW-1:0]      clr_idx,
  input  logic               clr_valid,
  output logic               any_pending,
  output logic [CW-1:0]      sel_idx
);

  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] masked;

  // A new edge on the bit being cleared keeps it pending.
  always_comb begin
    irq_d    = IRQ;
    clr_mask = '0;
    if (clr_valid) begin
      clr_mask = NUM_IRQ'(1) << clr_idx;
    end
    pend_d = (pend_q & ~clr_mask) | (IRQ & ~irq_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    masked      = pend_q & IRQ_EN;
    any_pending = |masked;
    sel_idx     = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (masked[i-1]) begin
        sel_idx = CW'(i - 1);
      end
    end
  end

endmodule

// File: rtl/control_fsm_mc.sv
// Multicycle core control FSM: fetch/exec/writeback sequencing, data-memory
// wait with timeout, and trap entry for interrupts and bus errors.
module control_fsm_mc import control_fsm_pkg::*; #(
  parameter  int NUM_IRQ     = 4,
  parameter  int INIT_CYCLES = 1,
  parameter  int WAIT_LIMIT  = 16,
  localparam int CW          = cause_width(NUM_IRQ)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               DECODER_RF_WE,
  input  logic               IS_MEM,
  input  logic               IS_MRET,
  input  logic               MEM_READY,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic [NUM_IRQ-1:0] IRQ_EN,
  input  logic               MIE,
  input  logic               MTVEC_READY,
  output logic               ir_we,
  output logic               pc_we,
  output logic               rf_we_out,
  output logic               mem_req,
  output logic [2:0]         ps,
  output logic               DO_MRET,
  output logic               TAKE_INTR,
  output logic [CW-1:0]      TRAP_CAUSE,
  output logic               BUS_ERR
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WW = $clog2(WAIT_LIMIT);

  fsm_state_t    state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          abort_q, abort_d;
  logic [CW-1:0] cause_q, cause_d;

  logic          init_done;
  logic          timeout;
  logic          any_pending;
  logic [CW-1:0] sel_idx;
  logic          clr_valid;
  logic          irq_take;

  assign init_done = (init_cnt_q == IW'(INIT_CYCLES - 1));
  assign timeout   = (wait_cnt_q == WW'(WAIT_LIMIT - 1));
  assign irq_take  = MIE && MTVEC_READY && any_pending;
  // Bus-error traps leave every interrupt pending bit untouched.
  assign clr_valid = (state_q == ST_TRAP) && (cause_q != CW'(NUM_IRQ));
  assign ps        = state_q;

  irq_pending #(
    .NUM_IRQ (NUM_IRQ),
    .CW      (CW)
  ) u_irq_pending (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .IRQ         (IRQ),
    .IRQ_EN      (IRQ_EN),
    .clr_idx     (cause_q),
    .clr_valid   (clr_valid),
    .any_pending (any_pending),
    .sel_idx     (sel_idx)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      abort_q    <= 1'b0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      abort_q    <= abort_d;
      cause_q    <= cause_d;
    end
  end

  // Cause is captured on trap entry so TAKE_INTR/TRAP_CAUSE are purely registered.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = '0;
    wait_cnt_d = wait_cnt_q;
    abort_d    = abort_q;
    cause_d    = cause_q;
    case (state_q)
      ST_INIT: begin
        if (init_done) begin
          state_d = ST_FETCH;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        abort_d    = 1'b0;
        wait_cnt_d = '0;
        state_d    = IS_MEM ? ST_MEM_WAIT : ST_WRITEBACK;
      end
      ST_MEM_WAIT: begin
        wait_cnt_d = wait_cnt_q + WW'(1);
        if (MEM_READY) begin
          state_d = ST_WRITEBACK;
        end else if (timeout) begin
          abort_d = 1'b1;
          if (MTVEC_READY) begin
            state_d = ST_TRAP;
            cause_d = CW'(NUM_IRQ);
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: begin
        abort_d = 1'b0;
        if (irq_take) begin
          state_d = ST_TRAP;
          cause_d = sel_idx;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_TRAP: state_d = ST_FETCH;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_we_out  = 1'b0;
    mem_req    = 1'b0;
    DO_MRET    = 1'b0;
    TAKE_INTR  = 1'b0;
    TRAP_CAUSE = '0;
    BUS_ERR    = 1'b0;
    case (state_q)
      ST_FETCH: ir_we = 1'b1;
      ST_EXEC:  DO_MRET = IS_MRET;
      ST_MEM_WAIT: begin
        mem_req = 1'b1;
        BUS_ERR = timeout && !MEM_READY;
      end
      ST_WRITEBACK: begin
        pc_we     = 1'b1;
        rf_we_out = DECODER_RF_WE && !abort_q;
      end
      ST_TRAP: begin
        pc_we      = 1'b1;
        TAKE_INTR  = 1'b1;
        TRAP_CAUSE = cause_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm_mc.sv
// Directed bench for control_fsm_mc: per-cycle expected state and output flags.
module tb_control_fsm_mc;

  localparam int NUM_IRQ = 4;
  localparam int CW      = 3;

  localparam logic [2:0] S_INIT = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2,
                         S_MW   = 3'd3, S_WB    = 3'd4, S_TRAP = 3'd5;

  // Flag order: {ir_we, pc_we, rf_we_out, mem_req, DO_MRET, TAKE_INTR, BUS_ERR}
  localparam logic [6:0] F_NONE = 7'b0000000, F_IR   = 7'b1000000,
                         F_PC   = 7'b0100000, F_PCRF = 7'b0110000,
                         F_MREQ = 7'b0001000, F_MRET = 7'b0000100,
                         F_TRAP = 7'b0100010, F_BERR = 7'b0001001;

  logic               clk;
  logic               RESET_N;
  logic               DECODER_RF_WE, IS_MEM, IS_MRET, MEM_READY, MIE, MTVEC_READY;
  logic [NUM_IRQ-1:0] IRQ, IRQ_EN;
  logic               ir_we, pc_we, rf_we_out, mem_req, DO_MRET, TAKE_INTR, BUS_ERR;
  logic [2:0]         ps;
  logic [CW-1:0]      TRAP_CAUSE;
  logic [12:0]        obs;

  int checks = 0;
  int errors = 0;

  control_fsm_mc #(
    .NUM_IRQ     (NUM_IRQ),
    .INIT_CYCLES (3),
    .WAIT_LIMIT  (16)
  ) dut (
    .CLK           (clk),
    .RESET_N       (RESET_N),
    .DECODER_RF_WE (DECODER_RF_WE),
    .IS_MEM        (IS_MEM),
    .IS_MRET       (IS_MRET),
    .MEM_READY     (MEM_READY),
    .IRQ           (IRQ),
    .IRQ_EN        (IRQ_EN),
    .MIE           (MIE),
    .MTVEC_READY   (MTVEC_READY),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .rf_we_out     (rf_we_out),
    .mem_req       (mem_req),
    .ps            (ps),
    .DO_MRET       (DO_MRET),
    .TAKE_INTR     (TAKE_INTR),
    .TRAP_CAUSE    (TRAP_CAUSE),
    .BUS_ERR       (BUS_ERR)
  );

  assign obs = {ps, ir_we, pc_we, rf_we_out, mem_req, DO_MRET, TAKE_INTR, BUS_ERR, TRAP_CAUSE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are driven at posedge+1; outputs are checked at posedge+2.
  task automatic step(input string tag, input logic [2:0] s, input logic [6:0] f,
                      input logic [2:0] c);
    #1;
    check_eq(tag, {19'd0, obs}, {19'd0, s, f, c});
    @(posedge clk);
    #1;
  endtask

  initial begin
    RESET_N = 1'b0; DECODER_RF_WE = 1'b1; IS_MEM = 1'b0; IS_MRET = 1'b0;
    MEM_READY = 1'b0; IRQ = '0; IRQ_EN = 4'hF; MIE = 1'b0; MTVEC_READY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", {19'd0, obs}, 32'd0);
    RESET_N = 1'b1;

    // Reset release, non-memory instruction
    step("init1", S_INIT, F_NONE, 0);
    step("init2", S_INIT, F_NONE, 0);
    step("init3", S_INIT, F_NONE, 0);
    step("fetch1", S_FETCH, F_IR, 0);
    step("exec1", S_EXEC, F_NONE, 0);
    step("wb1", S_WB, F_PCRF, 0);

    // Memory access ready on the fifth wait cycle, MRET pulse in EXEC
    step("fetch2", S_FETCH, F_IR, 0);
    IS_MEM = 1'b1; IS_MRET = 1'b1;
    step("exec_mret", S_EXEC, F_MRET, 0);
    IS_MRET = 1'b0;
    for (int i = 0; i < 4; i++) step("mw_ready", S_MW, F_MREQ, 0);
    MEM_READY = 1'b1;
    step("mw_ready_last", S_MW, F_MREQ, 0);
    MEM_READY = 1'b0; DECODER_RF_WE = 1'b0;
    step("wb_mem", S_WB, F_PC, 0);
    DECODER_RF_WE = 1'b1;

    // Timeout with mtvec: bus-error trap wins over IRQ3 raised mid-wait
    step("fetch3", S_FETCH, F_IR, 0);
    step("exec3", S_EXEC, F_NONE, 0);
    MIE = 1'b1;
    for (int i = 0; i < 15; i++) begin
      IRQ = (i == 1) ? 4'b1000 : 4'b0000;
      step("mw_to", S_MW, F_MREQ, 0);
    end
    IRQ = '0;
    step("mw_berr", S_MW, F_BERR, 0);
    step("trap_bus", S_TRAP, F_TRAP, 4);
    IS_MEM = 1'b0;
    step("fetch4", S_FETCH, F_IR, 0);
    step("exec4", S_EXEC, F_NONE, 0);
    step("wb4", S_WB, F_PCRF, 0);
    step("trap_irq3", S_TRAP, F_TRAP, 3);

    // Timeout without mtvec: aborted writeback
    step("fetch5", S_FETCH, F_IR, 0);
    IS_MEM = 1'b1;
    step("exec5", S_EXEC, F_NONE, 0);
    for (int i = 0; i < 15; i++) step("mw_to2", S_MW, F_MREQ, 0);
    MTVEC_READY = 1'b0;
    step("mw_berr_nomtvec", S_MW, F_BERR, 0);
    step("wb_abort", S_WB, F_PC, 0);
    MTVEC_READY = 1'b1; IS_MEM = 1'b0;

    // Simultaneous IRQ1/IRQ2: priority order
    IRQ = 4'b0110;
    step("fetch6", S_FETCH, F_IR, 0);
    IRQ = '0;
    step("exec6", S_EXEC, F_NONE, 0);
    step("wb6", S_WB, F_PCRF, 0);
    step("trap_c1", S_TRAP, F_TRAP, 1);
    step("fetch7", S_FETCH, F_IR, 0);
    step("exec7", S_EXEC, F_NONE, 0);
    step("wb7", S_WB, F_PCRF, 0);
    step("trap_c2", S_TRAP, F_TRAP, 2);
    step("fetch8", S_FETCH, F_IR, 0);
    step("exec8", S_EXEC, F_NONE, 0);
    step("wb8_idle", S_WB, F_PCRF, 0);

    // Masked IRQ1 stays pending until enabled
    IRQ_EN = 4'b1101; IRQ = 4'b0110;
    step("fetch9", S_FETCH, F_IR, 0);
    IRQ = '0;
    step("exec9", S_EXEC, F_NONE, 0);
    step("wb9", S_WB, F_PCRF, 0);
    step("trap_mask_c2", S_TRAP, F_TRAP, 2);
    step("fetch10", S_FETCH, F_IR, 0);
    step("exec10", S_EXEC, F_NONE, 0);
    step("wb_masked", S_WB, F_PCRF, 0);
    IRQ_EN = 4'hF;
    step("fetch11", S_FETCH, F_IR, 0);
    step("exec11", S_EXEC, F_NONE, 0);
    step("wb11", S_WB, F_PCRF, 0);
    step("trap_unmask_c1", S_TRAP, F_TRAP, 1);

    // MIE=0 defers IRQ0
    MIE = 1'b0; IRQ = 4'b0001;
    step("fetch12", S_FETCH, F_IR, 0);
    IRQ = '0;
    step("exec12", S_EXEC, F_NONE, 0);
    step("wb_mie0", S_WB, F_PCRF, 0);
    step("fetch13", S_FETCH, F_IR, 0);
    step("exec13", S_EXEC, F_NONE, 0);
    step("wb_mie0_b", S_WB, F_PCRF, 0);
    MIE = 1'b1;
    step("fetch14", S_FETCH, F_IR, 0);
    step("exec14", S_EXEC, F_NONE, 0);
    step("wb14", S_WB, F_PCRF, 0);
    step("trap_mie_c0", S_TRAP, F_TRAP, 0);

    // MTVEC_READY=0 defers IRQ0 the same way
    MTVEC_READY = 1'b0; IRQ = 4'b0001;
    step("fetch15", S_FETCH, F_IR, 0);
    IRQ = '0;
    step("exec15", S_EXEC, F_NONE, 0);
    step("wb_nomtvec", S_WB, F_PCRF, 0);
    MTVEC_READY = 1'b1;
    step("fetch16", S_FETCH, F_IR, 0);
    step("exec16", S_EXEC, F_NONE, 0);
    step("wb16", S_WB, F_PCRF, 0);
    step("trap_mtvec_c0", S_TRAP, F_TRAP, 0);

    // Asynchronous reset during MEM_WAIT clears state and pending IRQ3
    IRQ = 4'b1000;
    step("fetch17", S_FETCH, F_IR, 0);
    IRQ = '0; IS_MEM = 1'b1;
    step("exec17", S_EXEC, F_NONE, 0);
    step("mw_pre_reset", S_MW, F_MREQ, 0);
    RESET_N = 1'b0;
    #1;
    check_eq("async_reset", {19'd0, obs}, 32'd0);
    @(posedge clk);
    #1;
    RESET_N = 1'b1; IS_MEM = 1'b0;
    step("rinit1", S_INIT, F_NONE, 0);
    step("rinit2", S_INIT, F_NONE, 0);
    step("rinit3", S_INIT, F_NONE, 0);
    step("rfetch", S_FETCH, F_IR, 0);
    step("rexec", S_EXEC, F_NONE, 0);
    step("rwb", S_WB, F_PCRF, 0);
    step("fetch_after_reset", S_FETCH, F_IR, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm_mc.md
Name: control_fsm_mc

Overview:
Parametrised successor to the core's 4-state multicycle control FSM. Adds a variable-latency data-memory wait state with timeout, and NUM_IRQ edge-latched interrupt lines with per-line enables and fixed priority. Adds a dedicated TRAP state that reports a cause code.
Sits between the decoder/CSR file and the PC, IR, RF and memory write enables of the multicycle RISC-V core.

Parameters:
NUM_IRQ, 4, number of external interrupt lines (1..16)
INIT_CYCLES, 1, cycles spent in INIT after reset release (>=1)
WAIT_LIMIT, 16, max MEM_WAIT cycles before bus-error abort (>=2)
CW, $clog2(NUM_IRQ+1), width of TRAP_CAUSE (derived, not overridden)

Ports:
CLK  in  1  core clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
DECODER_RF_WE  in  1  decoder register-file write request
IS_MEM  in  1  current instruction is load/store
IS_MRET  in  1  current instruction is MRET
MEM_READY  in  1  data memory completes the access this cycle
IRQ  in  NUM_IRQ  external interrupt lines, level, synchronous to CLK
IRQ_EN  in  NUM_IRQ  per-line enable (mie bits)
MIE  in  1  global interrupt enable (mstatus.MIE)
MTVEC_READY  in  1  mtvec programmed
ir_we  out  1  latch instruction register
pc_we  out  1  update PC
rf_we_out  out  1  register-file write
mem_req  out  1  data-memory request, held through MEM_WAIT
ps  out  3  current state encoding
DO_MRET  out  1  MRET side-effect pulse
TAKE_INTR  out  1  trap entry pulse (PC loads mtvec)
TRAP_CAUSE  out  CW  cause, valid when TAKE_INTR=1, else 0
BUS_ERR  out  1  one-cycle timeout pulse

Behaviour:
- States (ps): INIT=000, FETCH=001, EXEC=010, MEM_WAIT=011, WRITEBACK=100, TRAP=101. Codes 110/111 go to INIT next cycle with all outputs 0.
- Reset (RESET_N=0, async): ps=INIT; init counter, wait counter, pending[] and irq_q[] cleared. All outputs are combinational from state and are therefore 0 during reset.
- Reset released mid-instruction: restart at INIT. No partial writes.
- INIT: stays INIT_CYCLES cycles, then FETCH.
- FETCH: ir_we=1 (IR latched on exit edge); next EXEC. Decoder inputs are valid from EXEC onward.
- EXEC: DO_MRET=IS_MRET.
  - IS_MEM=1 -> MEM_WAIT, wait counter cleared.
  - IS_MEM=0 -> WRITEBACK.
- MEM_WAIT: mem_req=1; wait counter increments each cycle.
  - MEM_READY=1 -> WRITEBACK. Ready wins over timeout in the same cycle.
  - Else, if counter==WAIT_LIMIT-1: BUS_ERR=1 and the access is aborted.
    - MTVEC_READY=1 -> TRAP with cause NUM_IRQ.
    - MTVEC_READY=0 -> WRITEBACK with rf_we_out forced 0.
- WRITEBACK: pc_we=1; rf_we_out=DECODER_RF_WE (unless aborted).
  - Next TRAP if MIE && MTVEC_READY && |(pending & IRQ_EN).
  - Else FETCH.
- TRAP: TAKE_INTR=1, pc_we=1 (PC loads mtvec, overriding WRITEBACK's update); next FETCH.
  - TRAP_CAUSE = NUM_IRQ for bus error. Otherwise the lowest index i with pending[i]&IRQ_EN[i] (index 0 highest priority).
  - The taken pending bit clears on the exit edge.
- Pending: irq_q <= IRQ every cycle; pending[i] sets on rising edge (IRQ[i] & ~irq_q[i]).
  - Set and clear of the same bit in the same cycle: set wins.
  - A pending bit persists while IRQ_EN[i]=0 and is taken once enabled.
- Interrupts are sampled only in WRITEBACK; an instruction in progress always completes first.
- A bus-error trap takes precedence over a pending IRQ; the IRQ remains pending.
- No combinational path from IRQ to TAKE_INTR: TAKE_INTR depends only on registered state and cause.

Decomposition:
- Package control_fsm_pkg: state enum fsm_state_t (3-bit, encodings above) and the localparam function for CW.
- Sub-module irq_pending: edge detect, pending register, masked priority encoder. Ports: CLK, RESET_N, IRQ, IRQ_EN, clr_idx, clr_valid; outputs any_pending, sel_idx.

Test Plan:
- Reset with INIT_CYCLES=3, non-memory instruction -> ps 000,000,000,001,010,100,001; ir_we in cycle 4, pc_we in cycle 6; rf_we_out mirrors DECODER_RF_WE=1.
- IS_MEM=1, MEM_READY after 5 cycles -> 5 MEM_WAIT cycles with mem_req=1, then WRITEBACK; BUS_ERR never asserts.
- IS_MEM=1, MEM_READY never, WAIT_LIMIT=16, MTVEC_READY=1 -> BUS_ERR on 16th MEM_WAIT cycle, then TRAP with TRAP_CAUSE=4, then FETCH. With MTVEC_READY=0 -> WRITEBACK with rf_we_out=0.
- IRQ[2] and IRQ[1] pulse together, IRQ_EN=4'b1111, MIE=1 -> TRAP cause 1; next WRITEBACK -> TRAP cause 2. With IRQ_EN[1]=0 the first trap has cause 2 and bit 1 stays pending.
- IRQ[0] edge while MIE=0 -> no TRAP; set MIE=1 later -> TRAP cause 0 at the next WRITEBACK. MTVEC_READY=0 blocks the trap identically.
- IS_MRET in EXEC -> DO_MRET single pulse. RESET_N low during MEM_WAIT -> ps=000 and pending cleared immediately, asynchronously.
